// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug access controller.
package rf_dbg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_DUMP    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_WRITE   = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/rf_debug_ctrl.sv
// Debug-access initiator for the register file: single read, single write
// and full dump commands in, one response per register out.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready high
// ST_CAPTURE | register file read data sampled into the response regs
// ST_WRITE   | one-cycle write pulse to the register file
// ST_RESP    | response presented, held until rsp_ready
module rf_debug_ctrl
    import rf_dbg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dbg_rd_addr,
    input  logic [DATA_W-1:0] dbg_rd_data,
    output logic              dbg_wrt_en,
    output logic [ADDR_W-1:0] dbg_wrt_addr,
    output logic [DATA_W-1:0] dbg_wrt_data,
    output logic              busy
);

    state_e state;
    state_e state_nxt;
    op_e    op_in;
    logic   dump_q;
    logic   wrt_en_q;
    logic   cmd_fire;
    logic   rsp_fire;

    assign op_in     = op_e'(cmd_op);
    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // A write pending when reset arrives must never reach the register file.
    assign dbg_wrt_en = wrt_en_q && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (op_in)
                        OP_READ,
                        OP_DUMP:  state_nxt = ST_CAPTURE;
                        OP_WRITE: state_nxt = (cmd_addr != '0) ? ST_WRITE : ST_RESP;
                        default:  state_nxt = ST_RESP;
                    endcase
                end
            end
            ST_CAPTURE: state_nxt = ST_RESP;
            ST_WRITE:   state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_fire) begin
                    state_nxt = (dump_q && !rsp_last) ? ST_CAPTURE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address sequencing, write strobe and response holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dump_q       <= 1'b0;
            wrt_en_q     <= 1'b0;
            dbg_rd_addr  <= '0;
            dbg_wrt_addr <= '0;
            dbg_wrt_data <= '0;
            rsp_addr     <= '0;
            rsp_data     <= '0;
            rsp_last     <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        dump_q <= 1'b0;
                        case (op_in)
                            OP_READ: begin
                                dbg_rd_addr <= cmd_addr;
                            end
                            OP_DUMP: begin
                                dbg_rd_addr <= '0;
                                dump_q      <= 1'b1;
                            end
                            OP_WRITE: begin
                                if (cmd_addr != '0) begin
                                    dbg_wrt_addr <= cmd_addr;
                                    dbg_wrt_data <= cmd_data;
                                    wrt_en_q     <= 1'b1;
                                end else begin
                                    // register 0 is hardwired; reject without touching the file
                                    rsp_addr <= cmd_addr;
                                    rsp_data <= '0;
                                    rsp_last <= 1'b1;
                                    rsp_err  <= 1'b1;
                                end
                            end
                            default: begin
                                rsp_addr <= cmd_addr;
                                rsp_data <= '0;
                                rsp_last <= 1'b1;
                                rsp_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_CAPTURE: begin
                    rsp_addr <= dbg_rd_addr;
                    rsp_data <= dbg_rd_data;
                    rsp_last <= !dump_q || (&dbg_rd_addr);
                    rsp_err  <= 1'b0;
                end
                ST_WRITE: begin
                    wrt_en_q <= 1'b0;
                    rsp_addr <= dbg_wrt_addr;
                    rsp_data <= dbg_wrt_data;
                    rsp_last <= 1'b1;
                    rsp_err  <= 1'b0;
                end
                ST_RESP: begin
                    // the counter stops at the last register; it never wraps back to 0
                    if (rsp_fire && dump_q && !rsp_last) begin
                        dbg_rd_addr <= dbg_rd_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_debug_ctrl.sv
// Directed bench for rf_debug_ctrl with a behavioural register file.
module tb_rf_debug_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          rsp_err;
    logic [AW-1:0] dbg_rd_addr;
    logic [DW-1:0] dbg_rd_data;
    logic          dbg_wrt_en;
    logic [AW-1:0] dbg_wrt_addr;
    logic [DW-1:0] dbg_wrt_data;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] rf [0:31];
    logic          preload = 1'b0;
    int            wrt_pulses = 0;
    logic [AW-1:0] last_wrt_addr = '0;

    always #5 clk = ~clk;

    rf_debug_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .rsp_err      (rsp_err),
        .dbg_rd_addr  (dbg_rd_addr),
        .dbg_rd_data  (dbg_rd_data),
        .dbg_wrt_en   (dbg_wrt_en),
        .dbg_wrt_addr (dbg_wrt_addr),
        .dbg_wrt_data (dbg_wrt_data),
        .busy         (busy)
    );

    assign dbg_rd_data = rf[dbg_rd_addr];

    // Register file model: preload pattern i*3, otherwise commit debug writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 3);
        end else if (dbg_wrt_en) begin
            rf[dbg_wrt_addr] <= dbg_wrt_data;
            wrt_pulses       <= wrt_pulses + 1;
            last_wrt_addr    <= dbg_wrt_addr;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a command at a falling edge, hold it until accepted, return in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    function automatic logic [127:0] rsp_vec();
        return {88'd0, rsp_valid, rsp_last, rsp_err, rsp_addr, rsp_data};
    endfunction

    function automatic logic [127:0] exp_vec(logic v, logic l, logic e, logic [AW-1:0] a, logic [DW-1:0] d);
        return {88'd0, v, l, e, a, d};
    endfunction

    function automatic logic [127:0] all_out();
        return {44'd0, rsp_valid, rsp_last, rsp_err, busy, dbg_wrt_en,
                rsp_addr, rsp_data, dbg_rd_addr, dbg_wrt_addr, dbg_wrt_data};
    endfunction

    task automatic run_dump(input bit rnd);
        int            idx = 0;
        int            cyc = 0;
        int            busy_cyc = 0;
        int            stall_err = 0;
        int            stalls = 0;
        bit            prev_stall = 1'b0;
        logic [127:0]  held = '0;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        issue(2'b10, '0, '0);
        while (busy && cyc < 1000) begin
            busy_cyc++;
            if (prev_stall && rsp_valid && rsp_vec() !== held) stall_err++;
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid) begin
                if (rsp_ready) begin
                    ea = idx[AW-1:0];
                    ed = 32'(idx * 3);
                    check(rnd ? "dump_rnd_rsp" : "dump_rsp", rsp_vec(),
                          exp_vec(1'b1, idx == 31, 1'b0, ea, ed));
                    idx++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held       = rsp_vec();
                    stalls++;
                end
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b1;
        check(rnd ? "dump_rnd_count" : "dump_count", idx, 32);
        if (rnd) begin
            check("dump_rnd_stable", stall_err, 0);
            check("dump_rnd_stalled", stalls > 0, 1);
        end else begin
            check("dump_cycles", busy_cyc, 64);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outs", all_out(), 0);
        check("reset_cmd_ready", cmd_ready, 1);

        // write 0xDEADBEEF to reg 5
        p0 = wrt_pulses;
        issue(2'b01, 5'd5, 32'hDEADBEEF);
        check("wr_t1_strobe", {dbg_wrt_en, dbg_wrt_addr, dbg_wrt_data}, {1'b1, 5'd5, 32'hDEADBEEF});
        check("wr_t1_noresp", {rsp_valid, busy}, 2'b01);
        @(negedge clk);
        check("wr_t2_rsp", rsp_vec(), exp_vec(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF));
        check("wr_t2_strobe_off", dbg_wrt_en, 0);
        @(negedge clk);
        check("wr_t3_idle", {busy, cmd_ready}, 2'b01);
        check("wr_pulses", wrt_pulses - p0, 1);
        check("wr_pulse_addr", last_wrt_addr, 5);
        check("wr_rf_commit", rf[5], 32'hDEADBEEF);

        // read reg 5
        issue(2'b00, 5'd5, '0);
        check("rd_t1_noresp", rsp_valid, 0);
        @(negedge clk);
        check("rd_t2_rsp", rsp_vec(), exp_vec(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF));
        wait_idle("rd_done");

        // write to reg 0 is rejected
        p0 = wrt_pulses;
        issue(2'b01, 5'd0, 32'h1234);
        check("wr0_t1_rsp", rsp_vec(), exp_vec(1'b1, 1'b1, 1'b1, 5'd0, 32'd0));
        check("wr0_no_strobe", dbg_wrt_en, 0);
        wait_idle("wr0_done");
        check("wr0_pulses", wrt_pulses - p0, 0);

        // illegal op
        p0 = wrt_pulses;
        issue(2'b11, 5'd7, 32'h5555);
        check("ill_t1_rsp", rsp_vec(), exp_vec(1'b1, 1'b1, 1'b1, 5'd7, 32'd0));
        wait_idle("ill_done");
        check("ill_pulses", wrt_pulses - p0, 0);

        // preload i*3 and dump, ready tied high then toggling
        preload = 1'b1;
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        run_dump(1'b0);
        check("dump_cmd_ready_after", cmd_ready, 1);
        run_dump(1'b1);
        wait_idle("dump_rnd_done");

        // reset while the addr 10 dump response is presented
        begin
            int n = 0;
            issue(2'b10, '0, '0);
            while (!(rsp_valid && rsp_addr == 5'd10) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rst_dump_reach10", {rsp_valid, rsp_addr}, {1'b1, 5'd10});
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_dump_outs", all_out(), 0);
        check("rst_dump_cmd_ready", cmd_ready, 1);
        issue(2'b00, 5'd5, '0);
        @(negedge clk);
        check("rst_dump_read", rsp_vec(), exp_vec(1'b1, 1'b1, 1'b0, 5'd5, 32'd15));
        wait_idle("rst_dump_read_done");

        // reset in the WRITE cycle
        p0 = wrt_pulses;
        issue(2'b01, 5'd9, 32'hCAFE);
        reset = 1'b1;
        #1;
        check("rst_wr_no_strobe", dbg_wrt_en, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_wr_outs", all_out(), 0);
        check("rst_wr_cmd_ready", cmd_ready, 1);
        check("rst_wr_pulses", wrt_pulses - p0, 0);
        check("rst_wr_rf_kept", rf[9], 32'd27);
        issue(2'b00, 5'd9, '0);
        @(negedge clk);
        check("rst_wr_read", rsp_vec(), exp_vec(1'b1, 1'b1, 1'b0, 5'd9, 32'd27));
        wait_idle("rst_wr_read_done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_debug_ctrl.md
# rf_debug_ctrl

Debug-access controller acting as the initiator on the register file's read and write ports. It accepts single-register read, single-register write and full-dump commands over a valid/ready command channel. It sequences the register file address lines and returns results over a valid/ready response channel. It sits beside the core datapath; `busy` tells the top level to halt the core and mux this block onto the register file ports.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width (2^ADDR_W registers)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_op`  in  2  00 read, 01 write, 10 dump, 11 illegal
- `cmd_addr`  in  ADDR_W  target register
- `cmd_data`  in  DATA_W  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`
- `rsp_addr`  out  ADDR_W  register the response refers to
- `rsp_data`  out  DATA_W  read data, or echoed write data
- `rsp_last`  out  1  final response of a command
- `rsp_err`  out  1  illegal op, or write to register 0
- `dbg_rd_addr`  out  ADDR_W  register file read address, registered
- `dbg_rd_data`  in  DATA_W  combinational register file read data
- `dbg_wrt_en`  out  1  register file write enable, registered
- `dbg_wrt_addr`  out  ADDR_W  write address
- `dbg_wrt_data`  out  DATA_W  write data
- `busy`  out  1  high whenever state != IDLE

## Operation
- States: IDLE, CAPTURE, WRITE, RESP.
- IDLE:
  - `cmd_ready`=1, only in IDLE.
  - On handshake, latch op/addr/data.
  - read: `dbg_rd_addr`←cmd_addr, clear dump flag, go to CAPTURE.
  - dump: `dbg_rd_addr`←0, set dump flag, go to CAPTURE.
  - write, addr≠0: go to WRITE.
  - write, addr=0: no write issued; go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - illegal op: go to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_addr`=cmd_addr.
- CAPTURE (one cycle):
  - `rsp_data`←`dbg_rd_data`, `rsp_addr`←`dbg_rd_addr`.
  - `rsp_last`←(!dump | `dbg_rd_addr`==all-ones).
  - Go to RESP.
- WRITE (one cycle):
  - `dbg_wrt_en`=1 with latched addr/data.
  - `rsp_data`←write data, `rsp_last`=1.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` held stable until `rsp_ready`.
  - On handshake: if dump and not last, `dbg_rd_addr`+1, go to CAPTURE; else go to IDLE.
- Dump covers registers 0..2^ADDR_W−1 in ascending order, exactly once each. The address counter never wraps; the last response ends the command.
- `dbg_wrt_en` is never high outside WRITE. Exactly one write pulse per legal write command.
- Back-pressure: `rsp_ready` low stalls RESP indefinitely. No data is lost or repeated.

## Timing
- Reset (clock edge with `reset`=1):
  - State→IDLE; dump flag cleared.
  - `rsp_valid`, `rsp_last`, `rsp_err`, `dbg_wrt_en`, `busy` → 0.
  - `rsp_addr`, `rsp_data`, `dbg_rd_addr`, `dbg_wrt_addr`, `dbg_wrt_data` → 0.
  - `cmd_ready`=1 from the first cycle after reset.
- Reset mid-operation: in-flight response dropped, pending write not issued, dump abandoned. No `dbg_wrt_en` on the reset cycle.
- Read accepted at edge T: `rsp_valid` first high in cycle T+2.
- Write accepted at T: `dbg_wrt_en` high in cycle T+1; register file commits at the end of T+1; `rsp_valid` high in T+2.
- Error response: `rsp_valid` high in T+1.
- Dump with `rsp_ready` tied high: 2 cycles per register, 64 cycles total; next command is accepted no earlier than one cycle after the last handshake.
- `busy` rises the cycle after acceptance and falls the cycle after the final response handshake.
- `cmd_valid` while not in IDLE is ignored (`cmd_ready`=0). The command must be held by the sender.

## Structure
- Shared package `rf_dbg_pkg`:
  - op codes `OP_READ`, `OP_WRITE`, `OP_DUMP`, `OP_ILLEGAL`
  - state enum
  - defaults for `DATA_W`/`ADDR_W`
- Single module; no sub-module needed. Response holding registers are inline.

## Test plan
- After reset: write 0xDEADBEEF to reg 5, then read reg 5. Required: `dbg_wrt_en` one cycle at T+1 with addr 5; read response has `rsp_addr`=5, `rsp_data`=0xDEADBEEF, `rsp_last`=1, `rsp_err`=0, at T+2.
- Write 0x1234 to reg 0. Required: `dbg_wrt_en` never high; response has `rsp_err`=1, `rsp_data`=0.
- Preload reg i = i×3, then dump with `rsp_ready` held high. Required: 32 responses, addr 0..31, data i×3, `rsp_last` only on addr 31, 64 cycles total.
- Dump with `rsp_ready` toggling pseudo-randomly. Required: same 32 responses in order, no duplicates, `rsp_*` stable while stalled.
- `cmd_op`=11. Required: `rsp_err`=1 at T+1, `rsp_last`=1, no register file write.
- Assert `reset` during a dump at the addr 10 response, and separately in the WRITE cycle. Required: outputs zero on the next cycle, no write pulse, `cmd_ready`=1, a subsequent read works normally.
